tile_sequencer: RTL



---
 rtl/tile_sequencer_if.sv | 47 ++++
 rtl/tile_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/tile_sequencer_if.sv
// Accumulator read-mode type and the instruction/weight/activation/control bundle
// between the matrix-unit issue logic and tile_sequencer.
package Acc_types;
    typedef enum logic {
        ACC_NORMAL = 1'b0,
        ACC_DIAG   = 1'b1
    } acc_rd_mode;
endpackage

interface tile_sequencer_if #(
    parameter int unsigned MAX_TILES = 16
);
    localparam int unsigned TW = (MAX_TILES > 1) ? $clog2(MAX_TILES) : 1;

    logic                   instr_valid_i;
    logic                   instr_ready_o;
    logic [TW-1:0]          instr_tiles_m1_i;
    logic                   instr_accumulate_i;
    logic                   weight_fifo_valid_i;
    logic                   activations_rdy_i;
    logic                   load_weights_o;
    logic                   weight_wr_buf_o;
    logic                   weight_rd_buf_o;
    logic                   load_activations_o;
    logic                   stall_compute_o;
    Acc_types::acc_rd_mode  acc_read_mode_o;
    logic                   acc_accumulate_o;
    logic [TW-1:0]          tile_idx_o;
    logic                   busy_o;
    logic                   done_o;

    modport slave (
        input  instr_valid_i, instr_tiles_m1_i, instr_accumulate_i,
               weight_fifo_valid_i, activations_rdy_i,
        output instr_ready_o, load_weights_o, weight_wr_buf_o, weight_rd_buf_o,
               load_activations_o, stall_compute_o, acc_read_mode_o,
               acc_accumulate_o, tile_idx_o, busy_o, done_o
    );

    modport master (
        output instr_valid_i, instr_tiles_m1_i, instr_accumulate_i,
               weight_fifo_valid_i, activations_rdy_i,
        input  instr_ready_o, load_weights_o, weight_wr_buf_o, weight_rd_buf_o,
               load_activations_o, stall_compute_o, acc_read_mode_o,
               acc_accumulate_o, tile_idx_o, busy_o, done_o
    );
endinterface

// File: rtl/tile_sequencer.sv
// Multi-tile systolic-array controller: per tile weight load, activation wait and
// ARRAY_DIM-cycle compute, with optional next-tile weight prefetch during compute.
module tile_sequencer #(
    parameter int unsigned ARRAY_DIM = 32,
    parameter int unsigned MAX_TILES = 16,
    parameter int unsigned PREFETCH  = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    tile_sequencer_if.slave  bus
);
    localparam int unsigned TW = (MAX_TILES > 1) ? $clog2(MAX_TILES) : 1;
    localparam int unsigned CW = $clog2(ARRAY_DIM + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(ARRAY_DIM - 1);
    localparam logic [CW-1:0] FULL      = CW'(ARRAY_DIM);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        WAIT_ACT,
        COMPUTE,
        DONE
    } state_t;

    state_t        state, state_nx;
    logic [TW-1:0] tiles_m1, tiles_m1_nx;
    logic [TW-1:0] tile_idx, tile_idx_nx;
    logic          accumulate, accumulate_nx;
    logic [CW-1:0] wcnt, wcnt_nx;
    logic [CW-1:0] pcnt, pcnt_nx;
    logic [CW-1:0] ccnt, ccnt_nx;

    logic          last_tile;
    logic          pf_load;
    logic          pf_beat;
    logic [CW-1:0] pcnt_inc;

    assign last_tile = (tile_idx == tiles_m1);
    // Prefetch window is decoded from registered state only; pcnt_inc adds this cycle's beat.
    assign pf_load   = (PREFETCH != 0) && (state == COMPUTE) && !last_tile && (pcnt < FULL);
    assign pf_beat   = pf_load && bus.weight_fifo_valid_i;
    assign pcnt_inc  = pcnt + CW'(pf_beat);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            tiles_m1   <= '0;
            tile_idx   <= '0;
            accumulate <= 1'b0;
            wcnt       <= '0;
            pcnt       <= '0;
            ccnt       <= '0;
        end else begin
            state      <= state_nx;
            tiles_m1   <= tiles_m1_nx;
            tile_idx   <= tile_idx_nx;
            accumulate <= accumulate_nx;
            wcnt       <= wcnt_nx;
            pcnt       <= pcnt_nx;
            ccnt       <= ccnt_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        tiles_m1_nx   = tiles_m1;
        tile_idx_nx   = tile_idx;
        accumulate_nx = accumulate;
        wcnt_nx       = wcnt;
        pcnt_nx       = pcnt;
        ccnt_nx       = ccnt;

        unique case (state)
            IDLE: begin
                if (bus.instr_valid_i) begin
                    tiles_m1_nx   = bus.instr_tiles_m1_i;
                    accumulate_nx = bus.instr_accumulate_i;
                    tile_idx_nx   = '0;
                    wcnt_nx       = '0;
                    pcnt_nx       = '0;
                    state_nx      = LOAD_W;
                end
            end
            LOAD_W: begin
                if (bus.weight_fifo_valid_i) begin
                    if (wcnt == LAST_BEAT) begin
                        wcnt_nx  = '0;
                        state_nx = WAIT_ACT;
                    end else begin
                        wcnt_nx = wcnt + CW'(1);
                    end
                end
            end
            WAIT_ACT: begin
                if (bus.activations_rdy_i) begin
                    ccnt_nx  = '0;
                    state_nx = COMPUTE;
                end
            end
            COMPUTE: begin
                pcnt_nx = pcnt_inc;
                ccnt_nx = ccnt + CW'(1);
                if (ccnt == LAST_BEAT) begin
                    ccnt_nx = '0;
                    pcnt_nx = '0;
                    if (last_tile) begin
                        state_nx = DONE;
                    end else begin
                        tile_idx_nx = tile_idx + TW'(1);
                        if ((PREFETCH != 0) && (pcnt_inc == FULL)) begin
                            state_nx = WAIT_ACT;
                        end else begin
                            // Partial prefetch: resume loading where the prefetch stopped.
                            wcnt_nx  = pcnt_inc;
                            state_nx = LOAD_W;
                        end
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        bus.instr_ready_o      = (state == IDLE);
        bus.load_weights_o     = (state == LOAD_W) || pf_load;
        bus.weight_wr_buf_o    = (state == LOAD_W) ? tile_idx[0] : (pf_load ? ~tile_idx[0] : 1'b0);
        bus.weight_rd_buf_o    = tile_idx[0];
        bus.load_activations_o = (state == WAIT_ACT) || (state == COMPUTE);
        bus.stall_compute_o    = (state != COMPUTE);
        bus.acc_read_mode_o    = (state == COMPUTE) ? Acc_types::ACC_DIAG : Acc_types::ACC_NORMAL;
        bus.acc_accumulate_o   = (state == COMPUTE) && (accumulate || (tile_idx != '0));
        bus.tile_idx_o         = tile_idx;
        bus.busy_o             = (state != IDLE);
        bus.done_o             = (state == DONE);
    end
endmodule
